// File: rtl/hazard_scoreboard_unit_pkg.sv
// rtl/hazard_scoreboard_unit_pkg.sv - shared mode/latency codes and latency lookup for the hazard scoreboard
// Purpose: pipeline register mode codes, latency class codes, and the per-class issue latency.
// Ports: none (package).
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_STALL  = 2'b01,
        MODE_FLUSH  = 2'b10
    } pipe_mode_e;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'b00,
        LAT_LOAD = 2'b01,
        LAT_LONG = 2'b10
    } lat_class_e;

    // Cycles from issue until the result is forwardable to an EXE consumer.
    // Unassigned class code 2'b11 is treated as single-cycle ALU.
    function automatic int unsigned class_latency(input lat_class_e cls,
                                                  input int unsigned load_lat,
                                                  input int unsigned long_lat);
        case (cls)
            LAT_LOAD: return load_lat;
            LAT_LONG: return long_lat;
            default:  return 1;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// rtl/hazard_scoreboard_unit_if.sv - ID-side request and pipeline-control bundle for the hazard scoreboard
// Purpose: groups the ID instruction description, redirect/trap/EXE status and the resulting
//          pipeline controls and perf counters.
// Modports: master = pipeline side (drives ID info, observes controls);
//           slave  = hazard_scoreboard_unit.
interface hazard_scoreboard_unit_if
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int GPR_AW = 5,
    parameter int PERF_W = 32
) ();

    logic              id_valid;
    logic [GPR_AW-1:0] id_rs1_addr;
    logic              id_rs1_re;
    logic [GPR_AW-1:0] id_rs2_addr;
    logic              id_rs2_re;
    logic [GPR_AW-1:0] id_rd_addr;
    logic              id_rd_we;
    lat_class_e        id_lat_class;
    logic              id_early_use;
    logic              br_redirect;
    logic              trap_flush;
    logic              exe_ready;

    logic              if_stall;
    pipe_mode_e        if_id_mode;
    pipe_mode_e        id_exe_mode;
    logic              id_fire;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_cycles;

    modport master (
        output id_valid, id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re,
               id_rd_addr, id_rd_we, id_lat_class, id_early_use,
               br_redirect, trap_flush, exe_ready,
        input  if_stall, if_id_mode, id_exe_mode, id_fire, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re,
               id_rd_addr, id_rd_we, id_lat_class, id_early_use,
               br_redirect, trap_flush, exe_ready,
        output if_stall, if_id_mode, id_exe_mode, id_fire, stall_cycles, flush_cycles
    );

endinterface

// File: rtl/hazard_scoreboard_unit_gpr_scoreboard.sv
// rtl/hazard_scoreboard_unit_gpr_scoreboard.sv - per-GPR pending-write latency countdown array
// Purpose: one countdown per register; issue loads the class latency, otherwise nonzero
//          counts decrement; hold freezes everything; clear empties the board.
// Ports: clk, rst (sync active-high), clear, hold, issue_we/issue_addr/issue_class,
//        two lookup ports rd_addr_a/cnt_a and rd_addr_b/cnt_b.
module gpr_scoreboard
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int GPR_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int LONG_LAT = 4,
    parameter int CW       = $clog2(LONG_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hold,
    input  logic              issue_we,
    input  logic [GPR_AW-1:0] issue_addr,
    input  lat_class_e        issue_class,
    input  logic [GPR_AW-1:0] rd_addr_a,
    input  logic [GPR_AW-1:0] rd_addr_b,
    output logic [CW-1:0]     cnt_a,
    output logic [CW-1:0]     cnt_b
);

    localparam int NREG = 2 ** GPR_AW;

    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] issue_lat;

    assign issue_lat = CW'(class_latency(issue_class, LOAD_LAT, LONG_LAT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (!hold) begin
            for (int r = 0; r < NREG; r++) begin
                // x0 is never tracked, so it can never look busy.
                if (issue_we && (issue_addr == GPR_AW'(r)) && (r != 0))
                    cnt[r] <= issue_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    assign cnt_a = cnt[rd_addr_a];
    assign cnt_b = cnt[rd_addr_b];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - scoreboard-based hazard control beside ID
// Purpose: stalls on pending GPR writes, freezes on EXE busy, flushes on branch/trap,
//          selects IF_ID / ID_EXE modes and keeps saturating stall/flush perf counters.
// Ports: clk, rst (sync active-high), hz (slave modport: ID info in, pipeline controls out).
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int GPR_AW         = 5,
    parameter int LOAD_LAT       = 2,
    parameter int LONG_LAT       = 4,
    parameter int BR_FLUSH_DEPTH = 1,
    parameter int PERF_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_scoreboard_unit_if.slave hz
);

    localparam int CW = $clog2(LONG_LAT + 1);
    localparam int FW = $clog2(BR_FLUSH_DEPTH + 1);

    logic [CW-1:0]     cnt_rs1;
    logic [CW-1:0]     cnt_rs2;
    logic [FW-1:0]     flush_ctr;
    logic [FW-1:0]     flush_ctr_nxt;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              data_hazard;
    logic              id_fire_c;
    logic              if_stall_c;
    pipe_mode_e        if_id_mode_c;
    pipe_mode_e        id_exe_mode_c;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    gpr_scoreboard #(
        .GPR_AW  (GPR_AW),
        .LOAD_LAT(LOAD_LAT),
        .LONG_LAT(LONG_LAT),
        .CW      (CW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .clear      (hz.trap_flush),
        .hold       (!hz.exe_ready),
        .issue_we   (id_fire_c && hz.id_rd_we),
        .issue_addr (hz.id_rd_addr),
        .issue_class(hz.id_lat_class),
        .rd_addr_a  (hz.id_rs1_addr),
        .rd_addr_b  (hz.id_rs2_addr),
        .cnt_a      (cnt_rs1),
        .cnt_b      (cnt_rs2)
    );

    // Consumers in ID need the value fully written back (cnt==0); EXE consumers can
    // take it from the bypass network one cycle earlier (cnt<=1).
    assign rs1_busy = hz.id_rs1_re && (hz.id_rs1_addr != '0) &&
                      (hz.id_early_use ? (cnt_rs1 != '0) : (cnt_rs1 >= CW'(2)));
    assign rs2_busy = hz.id_rs2_re && (hz.id_rs2_addr != '0) &&
                      (hz.id_early_use ? (cnt_rs2 != '0) : (cnt_rs2 >= CW'(2)));
    assign data_hazard = rs1_busy || rs2_busy;

    assign id_fire_c = hz.id_valid && hz.exe_ready && !data_hazard &&
                       !hz.trap_flush && (flush_ctr == '0);

    always_comb begin
        if_id_mode_c  = MODE_NORMAL;
        id_exe_mode_c = MODE_NORMAL;
        if_stall_c    = 1'b0;
        flush_ctr_nxt = flush_ctr;
        if (hz.trap_flush) begin
            if_id_mode_c  = MODE_FLUSH;
            id_exe_mode_c = MODE_FLUSH;
            flush_ctr_nxt = '0;
        end else if (!hz.exe_ready) begin
            if_id_mode_c  = MODE_STALL;
            id_exe_mode_c = MODE_STALL;
            if_stall_c    = 1'b1;
        end else if (data_hazard) begin
            // Bubble into EXE; a redirect from a stalled branch is not yet valid.
            if_id_mode_c  = MODE_STALL;
            id_exe_mode_c = MODE_FLUSH;
            if_stall_c    = 1'b1;
        end else if (flush_ctr != '0) begin
            if_id_mode_c  = MODE_FLUSH;
            flush_ctr_nxt = flush_ctr - 1'b1;
        end else if (hz.br_redirect) begin
            if_id_mode_c  = MODE_FLUSH;
            flush_ctr_nxt = FW'(BR_FLUSH_DEPTH - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_ctr <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            flush_ctr <= flush_ctr_nxt;
            if (if_stall_c && (stall_cnt != {PERF_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if ((if_id_mode_c == MODE_FLUSH) && (flush_cnt != {PERF_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.if_stall     = if_stall_c;
    assign hz.if_id_mode   = if_id_mode_c;
    assign hz.id_exe_mode  = id_exe_mode_c;
    assign hz.id_fire      = id_fire_c;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_cycles = flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;
    import hazard_scoreboard_unit_pkg::*;

    localparam int PERF_W = 4;
    localparam int PERF_MAX = 15;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_scoreboard_unit_if #(.GPR_AW(5), .PERF_W(PERF_W)) hz ();

    hazard_scoreboard_unit #(
        .GPR_AW        (5),
        .LOAD_LAT      (2),
        .LONG_LAT      (4),
        .BR_FLUSH_DEPTH(2),
        .PERF_W        (PERF_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       re1;
        logic [4:0] rs2;
        logic       re2;
        logic [4:0] rd;
        logic       we;
        lat_class_e cls;
        logic       early;
        logic       br;
        logic       trap;
        logic       exe;
        logic       x_stall;
        pipe_mode_e x_ifid;
        pipe_mode_e x_idexe;
        logic       x_fire;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int valid, input int rs1, input int re1, input int rs2,
                                input int re2, input int rd, input int we, input lat_class_e cls,
                                input int early, input int br, input int trap, input int exe,
                                input int x_stall, input pipe_mode_e x_ifid,
                                input pipe_mode_e x_idexe, input int x_fire);
        vec_t v;
        v.valid = 1'(valid); v.rs1 = 5'(rs1); v.re1 = 1'(re1); v.rs2 = 5'(rs2);
        v.re2 = 1'(re2); v.rd = 5'(rd); v.we = 1'(we); v.cls = cls; v.early = 1'(early);
        v.br = 1'(br); v.trap = 1'(trap); v.exe = 1'(exe); v.x_stall = 1'(x_stall);
        v.x_ifid = x_ifid; v.x_idexe = x_idexe; v.x_fire = 1'(x_fire);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        hz.id_valid     = v.valid;
        hz.id_rs1_addr  = v.rs1;
        hz.id_rs1_re    = v.re1;
        hz.id_rs2_addr  = v.rs2;
        hz.id_rs2_re    = v.re2;
        hz.id_rd_addr   = v.rd;
        hz.id_rd_we     = v.we;
        hz.id_lat_class = v.cls;
        hz.id_early_use = v.early;
        hz.br_redirect  = v.br;
        hz.trap_flush   = v.trap;
        hz.exe_ready    = v.exe;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int idx, input vec_t v);
        chk({tag, ".if_stall"}, idx, 32'(hz.if_stall), 32'(v.x_stall));
        chk({tag, ".if_id_mode"}, idx, 32'(hz.if_id_mode), 32'(v.x_ifid));
        chk({tag, ".id_exe_mode"}, idx, 32'(hz.id_exe_mode), 32'(v.x_idexe));
        chk({tag, ".id_fire"}, idx, 32'(hz.id_fire), 32'(v.x_fire));
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        int   exp_stall;
        int   exp_flush;

        checks = 0;
        errors = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, LAT_ALU, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 0);

        //        vld rs1 re rs2 re rd we cls      ear br tr exe | stall ifid         idexe        fire
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, LAT_LOAD, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 0 lw x5
        tbl.push_back(mk(1, 5, 1, 0, 1, 6, 1, LAT_ALU,  0, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 1 add uses x5
        tbl.push_back(mk(1, 5, 1, 0, 1, 6, 1, LAT_ALU,  0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 2 fires
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, LAT_ALU,  0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 3 alu x7
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 0, LAT_ALU,  1, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 4 beq x7
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 0, LAT_ALU,  1, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 5
        tbl.push_back(mk(1, 2, 1, 0, 0, 7, 1, LAT_LOAD, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 6 lw x7
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 0, LAT_ALU,  1, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 7 beq
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 0, LAT_ALU,  1, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 8
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 0, LAT_ALU,  1, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 9
        tbl.push_back(mk(1, 3, 1, 4, 1, 9, 1, LAT_LONG, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 10 mul x9
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 0, 1, MODE_STALL,  MODE_STALL,  0)); // 11 exe busy
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 0, 1, MODE_STALL,  MODE_STALL,  0)); // 12
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 0, 1, MODE_STALL,  MODE_STALL,  0)); // 13
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 14 cnt=4
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 15 cnt=3
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 16 cnt=2
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, LAT_ALU, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 17 cnt=1
        tbl.push_back(mk(1, 1, 1, 2, 1, 0, 0, LAT_ALU,  1, 1, 0, 1, 0, MODE_FLUSH,  MODE_NORMAL, 1)); // 18 taken br
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, LAT_ALU,  0, 0, 0, 1, 0, MODE_FLUSH,  MODE_NORMAL, 0)); // 19 2nd flush
        tbl.push_back(mk(1, 1, 1, 2, 1, 1, 1, LAT_ALU,  0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 20
        tbl.push_back(mk(1, 2, 1, 0, 0, 5, 1, LAT_LOAD, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 21 lw x5
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, LAT_ALU,  0, 0, 1, 1, 0, MODE_FLUSH,  MODE_FLUSH,  0)); // 22 trap
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, LAT_ALU,  0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 23 no stall
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 1, LAT_LOAD, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 24 lw x0
        tbl.push_back(mk(1, 0, 1, 0, 1, 13, 1, LAT_ALU, 1, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 25 uses x0
        tbl.push_back(mk(1, 2, 1, 0, 0, 11, 1, LAT_LOAD, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 26 lw x11
        tbl.push_back(mk(1, 11, 1, 0, 0, 0, 0, LAT_ALU, 0, 1, 0, 1, 1, MODE_STALL,  MODE_FLUSH,  0)); // 27 br ignored
        tbl.push_back(mk(1, 11, 1, 0, 0, 0, 0, LAT_ALU, 0, 1, 0, 1, 0, MODE_FLUSH,  MODE_NORMAL, 1)); // 28 br taken
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, LAT_ALU,  0, 0, 0, 1, 0, MODE_FLUSH,  MODE_NORMAL, 0)); // 29 killed
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, LAT_ALU,  0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 0)); // 30 idle
        tbl.push_back(mk(1, 2, 1, 0, 0, 12, 1, LAT_LOAD, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 31 lw x12
        tbl.push_back(mk(1, 1, 1, 12, 1, 14, 1, LAT_ALU, 0, 0, 0, 1, 1, MODE_STALL, MODE_FLUSH,  0)); // 32 rs2 hazard
        tbl.push_back(mk(1, 1, 1, 12, 1, 14, 1, LAT_ALU, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1)); // 33

        // Reset state
        rst = 1'b1;
        apply(idle);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_outputs("reset", 0, idle);
        chk("reset.stall_cycles", 0, 32'(hz.stall_cycles), 32'd0);
        chk("reset.flush_cycles", 0, 32'(hz.flush_cycles), 32'd0);

        // Table-driven sequence; perf expectations follow the expected outputs.
        exp_stall = 0;
        exp_flush = 0;
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk_outputs("vec", i, tbl[i]);
            if (tbl[i].x_stall && exp_stall < PERF_MAX) exp_stall++;
            if (tbl[i].x_ifid == MODE_FLUSH && exp_flush < PERF_MAX) exp_flush++;
        end
        @(negedge clk);
        apply(idle);
        #1;
        chk("perf.stall_cycles", 0, 32'(hz.stall_cycles), 32'(exp_stall));
        chk("perf.flush_cycles", 0, 32'(hz.flush_cycles), 32'(exp_flush));

        // Reset in the middle of a branch flush with x5 pending.
        @(negedge clk);
        v = mk(1, 1, 1, 0, 0, 5, 1, LAT_LOAD, 0, 1, 0, 1, 0, MODE_FLUSH, MODE_NORMAL, 1);
        apply(v);
        #1;
        chk_outputs("pre_rst", 0, v);
        @(negedge clk);
        rst = 1'b1;
        apply(idle);
        @(negedge clk);
        rst = 1'b0;
        v = mk(1, 5, 1, 0, 0, 6, 1, LAT_ALU, 0, 0, 0, 1, 0, MODE_NORMAL, MODE_NORMAL, 1);
        apply(v);
        #1;
        chk_outputs("post_rst", 0, v);
        chk("post_rst.stall_cycles", 0, 32'(hz.stall_cycles), 32'd0);
        chk("post_rst.flush_cycles", 0, 32'(hz.flush_cycles), 32'd0);

        // Stall counter saturation with EXE busy.
        v = idle;
        v.exe = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(v);
        end
        @(negedge clk);
        #1;
        chk("sat.stall_at_15", 0, 32'(hz.stall_cycles), 32'(PERF_MAX));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            apply(v);
        end
        @(negedge clk);
        #1;
        chk("sat.stall_held", 0, 32'(hz.stall_cycles), 32'(PERF_MAX));

        // Flush counter saturation with trap held.
        v = idle;
        v.trap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            apply(v);
            #1;
            if (i == 0) chk("trap.if_stall", 0, 32'(hz.if_stall), 32'd0);
        end
        @(negedge clk);
        apply(idle);
        #1;
        chk("sat.flush_held", 0, 32'(hz.flush_cycles), 32'(PERF_MAX));
        chk("sat.stall_after_trap", 0, 32'(hz.stall_cycles), 32'(PERF_MAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
